// File: rtl/dca_matrix_stream_register_if.sv
// Load/store stream bundle for dca_matrix_stream_register.
// The slave modport is the register side; the master modport is the producer/consumer.
interface dca_matrix_stream_register_if #(
  parameter int unsigned MATRIX_SIZE_PARA = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  parameter int unsigned ROWS_PER_BEAT    = 1
);
  localparam int unsigned BeatW = ROWS_PER_BEAT * MATRIX_SIZE_PARA * BW_TENSOR_SCALAR;

  logic             s_valid;
  logic             s_ready;
  logic [BeatW-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [BeatW-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/dca_matrix_stream_register.sv
// N x N element register loaded/stored as a stream of R rows or columns per beat.
// DCA_MATRIX_STREAM_ROTATE_EN: store refills vacated slots with emitted data (matrix preserved).
module dca_matrix_stream_register #(
  parameter int unsigned MATRIX_SIZE_PARA = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  parameter int unsigned ROWS_PER_BEAT    = 1,
  parameter logic [BW_TENSOR_SCALAR-1:0] RESET_VALUE = '0,
  parameter logic [BW_TENSOR_SCALAR-1:0] INIT_VALUE  = RESET_VALUE
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic load_req,
  input  logic store_req,
  input  logic col_mode,
  dca_matrix_stream_register_if.slave strm,
  output logic busy,
  output logic load_done,
  output logic store_done,
  input  logic [MATRIX_SIZE_PARA*MATRIX_SIZE_PARA-1:0]                  all_wenable_list2d,
  input  logic [MATRIX_SIZE_PARA*MATRIX_SIZE_PARA*BW_TENSOR_SCALAR-1:0] all_wdata_list2d,
  output logic [MATRIX_SIZE_PARA*MATRIX_SIZE_PARA*BW_TENSOR_SCALAR-1:0] all_rdata_list2d
);
  localparam int unsigned N     = MATRIX_SIZE_PARA;
  localparam int unsigned BW    = BW_TENSOR_SCALAR;
  localparam int unsigned R     = ROWS_PER_BEAT;
  localparam int unsigned Beats = N / R;
  localparam int unsigned CntW  = $clog2(Beats + 1);

  if (MATRIX_SIZE_PARA % ROWS_PER_BEAT != 0) begin : g_bad_rows_per_beat
    $error("ROWS_PER_BEAT must divide MATRIX_SIZE_PARA");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StStore = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              col_q, col_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load_done_q, load_done_d;
  logic              store_done_q, store_done_d;
  logic [N*N*BW-1:0] mat_q, mat_d, shifted;
  logic [R*N*BW-1:0] beat_out, store_fill, shift_in;
  logic              fire, last;

  // Outgoing beat: rows 0..R-1, or columns 0..R-1 laid out as beat row k = column k.
  always_comb begin
    beat_out = '0;
    for (int unsigned k = 0; k < R; k++) begin
      for (int unsigned c = 0; c < N; c++) begin
        beat_out[(k*N+c)*BW +: BW] = col_q ? mat_q[(c*N+k)*BW +: BW] : mat_q[(k*N+c)*BW +: BW];
      end
    end
  end

`ifdef DCA_MATRIX_STREAM_ROTATE_EN
  assign store_fill = beat_out;
`else
  assign store_fill = {(R*N){RESET_VALUE}};
`endif

  assign shift_in = (state_q == StLoad) ? strm.s_data : store_fill;

  // Shift by R rows/columns; the modulo indexing keeps every select in range when unrolled.
  always_comb begin
    shifted = mat_q;
    for (int unsigned r = 0; r < N; r++) begin
      for (int unsigned c = 0; c < N; c++) begin
        if (!col_q) begin
          if (r < N - R) shifted[(r*N+c)*BW +: BW] = mat_q[(((r+R)%N)*N+c)*BW +: BW];
          else           shifted[(r*N+c)*BW +: BW] = shift_in[((((r+R)%N)%R)*N+c)*BW +: BW];
        end else begin
          if (c < N - R) shifted[(r*N+c)*BW +: BW] = mat_q[(r*N+((c+R)%N))*BW +: BW];
          else           shifted[(r*N+c)*BW +: BW] = shift_in[((((c+R)%N)%R)*N+r)*BW +: BW];
        end
      end
    end
  end

  assign fire = ((state_q == StLoad) && strm.s_valid) || ((state_q == StStore) && strm.m_ready);
  assign last = fire && (cnt_q == CntW'(Beats - 1));

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    cnt_d        = cnt_q;
    mat_d        = mat_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    if (init) begin
      mat_d   = {(N*N){INIT_VALUE}};
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          for (int unsigned i = 0; i < N*N; i++) begin
            if (all_wenable_list2d[i]) mat_d[i*BW +: BW] = all_wdata_list2d[i*BW +: BW];
          end
          if (load_req) begin
            state_d = StLoad;
            col_d   = col_mode;
            cnt_d   = '0;
          end else if (store_req) begin
            state_d = StStore;
            col_d   = col_mode;
            cnt_d   = '0;
          end
        end
        StLoad, StStore: begin
          if (fire) begin
            mat_d = shifted;
            cnt_d = cnt_q + CntW'(1);
          end
          if (last) begin
            state_d      = StIdle;
            cnt_d        = '0;
            load_done_d  = (state_q == StLoad);
            store_done_d = (state_q == StStore);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      col_q        <= 1'b0;
      cnt_q        <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      mat_q        <= {(N*N){RESET_VALUE}};
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      cnt_q        <= cnt_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      mat_q        <= mat_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign strm.s_ready     = (state_q == StLoad);
  assign strm.m_valid     = (state_q == StStore);
  assign strm.m_data      = beat_out;
  assign load_done        = load_done_q;
  assign store_done       = store_done_q;
  assign all_rdata_list2d = mat_q;
endmodule

// File: tb/tb_dca_matrix_stream_register.sv
// Randomized bench for dca_matrix_stream_register (N=4, BW=8; R=1 and R=2 instances).
// Expected matrices come from a 2-D element model updated by whole-stream rules.
module tb_dca_matrix_stream_register;
  localparam logic [7:0] InitV = 8'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, init, load_req, store_req, col_mode;
  logic         busy, load_done, store_done;
  logic [15:0]  wen;
  logic [127:0] wdata, rdata;
  logic         b_init, b_load_req, b_store_req, b_col_mode;
  logic         b_busy, b_load_done, b_store_done;
  logic [15:0]  b_wen;
  logic [127:0] b_wdata, b_rdata;

  dca_matrix_stream_register_if #(.MATRIX_SIZE_PARA(4), .BW_TENSOR_SCALAR(8),
                                  .ROWS_PER_BEAT(1)) ifa ();
  dca_matrix_stream_register_if #(.MATRIX_SIZE_PARA(4), .BW_TENSOR_SCALAR(8),
                                  .ROWS_PER_BEAT(2)) ifb ();

  dca_matrix_stream_register #(.MATRIX_SIZE_PARA(4), .BW_TENSOR_SCALAR(8), .ROWS_PER_BEAT(1),
                               .RESET_VALUE(8'h00), .INIT_VALUE(InitV)) dut_a (
    .clk(clk), .rst(rst), .init(init), .load_req(load_req), .store_req(store_req),
    .col_mode(col_mode), .strm(ifa), .busy(busy), .load_done(load_done),
    .store_done(store_done), .all_wenable_list2d(wen), .all_wdata_list2d(wdata),
    .all_rdata_list2d(rdata)
  );

  dca_matrix_stream_register #(.MATRIX_SIZE_PARA(4), .BW_TENSOR_SCALAR(8), .ROWS_PER_BEAT(2),
                               .RESET_VALUE(8'h00), .INIT_VALUE(InitV)) dut_b (
    .clk(clk), .rst(rst), .init(b_init), .load_req(b_load_req), .store_req(b_store_req),
    .col_mode(b_col_mode), .strm(ifb), .busy(b_busy), .load_done(b_load_done),
    .store_done(b_store_done), .all_wenable_list2d(b_wen), .all_wdata_list2d(b_wdata),
    .all_rdata_list2d(b_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mdl  [4][4];
  logic [7:0] mdlb [4][4];

  function automatic logic [127:0] pack_mdl();
    logic [127:0] v;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) v[(r*4+c)*8 +: 8] = mdl[r][c];
    return v;
  endfunction

  function automatic logic [127:0] pack_mdlb();
    logic [127:0] v;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) v[(r*4+c)*8 +: 8] = mdlb[r][c];
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    #1;
    vectors++;
    if ({busy, ifa.s_ready, ifa.m_valid, load_done, store_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_a: got %b expected 00000",
               {busy, ifa.s_ready, ifa.m_valid, load_done, store_done});
    end
    vectors++;
    if ({b_busy, ifb.s_ready, ifb.m_valid, b_load_done, b_store_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs_b: got %b expected 00000",
               {b_busy, ifb.s_ready, ifb.m_valid, b_load_done, b_store_done});
    end
    repeat (2) @(negedge clk);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      mdl[r][c] = 8'h00;
      mdlb[r][c] = 8'h00;
    end
    vectors++;
    if (rdata !== pack_mdl()) begin
      miscompares++;
      $display("FAIL reset_matrix: got %h expected %h", rdata, pack_mdl());
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_write();
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      wen   = 16'($urandom);
      wdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      for (int i = 0; i < 16; i++) if (wen[i]) mdl[i/4][i%4] = wdata[i*8 +: 8];
      wen = '0;
      vectors++;
      if (rdata !== pack_mdl()) begin
        miscompares++;
        $display("FAIL idle_write: got %h expected %h", rdata, pack_mdl());
      end
    end
  endtask

  task automatic test_load(input bit cm, input bit gapped, input bit both, input bit junk,
                           input bit fixed);
    logic [31:0] beats [4];
    int acc;
    bit v, rdy;
    for (int i = 0; i < 4; i++)
      beats[i] = fixed ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : $urandom;
    @(negedge clk);
    load_req = 1'b1; store_req = both; col_mode = cm;
    @(negedge clk);
    load_req = 1'b0; store_req = 1'b0; col_mode = 1'($urandom);
    vectors++;
    if ({ifa.s_ready, ifa.m_valid, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL load_enter: got %b expected 101", {ifa.s_ready, ifa.m_valid, busy});
    end
    if (junk) begin
      wen = '1;
      wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 4; cyc++) begin
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      ifa.s_valid = v;
      ifa.s_data  = beats[acc];
      rdy = ifa.s_ready;
      @(negedge clk);
      if (v && rdy) acc++;
      if (acc < 4) begin
        vectors++;
        if (load_done !== 1'b0) begin
          miscompares++;
          $display("FAIL load_done_early: got %b expected 0 after %0d beats", load_done, acc);
        end
      end
    end
    ifa.s_valid = 1'b0;
    wen = '0;
    if (acc < 4) begin
      miscompares++;
      $display("FAIL load_timeout: got %0d beats expected 4", acc);
    end
    for (int j = 0; j < 4; j++) for (int c = 0; c < 4; c++) begin
      if (cm) mdl[c][j] = beats[j][c*8 +: 8];
      else    mdl[j][c] = beats[j][c*8 +: 8];
    end
    vectors++;
    if ({load_done, busy, ifa.s_ready} !== 3'b100) begin
      miscompares++;
      $display("FAIL load_finish: got done/busy/ready %b expected 100",
               {load_done, busy, ifa.s_ready});
    end
    vectors++;
    if (rdata !== pack_mdl()) begin
      miscompares++;
      $display("FAIL load_matrix: got %h expected %h", rdata, pack_mdl());
    end
    @(negedge clk);
    vectors++;
    if (load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL load_done_width: got %b expected 0", load_done);
    end
  endtask

  task automatic test_store(input bit cm, input bit toggle);
    logic [31:0] expb [4];
    int acc;
    bit r, take;
    for (int j = 0; j < 4; j++) for (int c = 0; c < 4; c++)
      expb[j][c*8 +: 8] = cm ? mdl[c][j] : mdl[j][c];
    @(negedge clk);
    store_req = 1'b1; col_mode = cm;
    @(negedge clk);
    store_req = 1'b0;
    vectors++;
    if ({ifa.m_valid, ifa.s_ready, busy} !== 3'b101) begin
      miscompares++;
      $display("FAIL store_enter: got %b expected 101", {ifa.m_valid, ifa.s_ready, busy});
    end
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 4; cyc++) begin
      r = toggle ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      ifa.m_ready = r;
      load_req = 1'($urandom_range(0, 1));
      take = r && ifa.m_valid;
      if (take) begin
        vectors++;
        if (ifa.m_data !== expb[acc]) begin
          miscompares++;
          $display("FAIL store_beat%0d: got %h expected %h", acc, ifa.m_data, expb[acc]);
        end
      end
      @(negedge clk);
      if (take) acc++;
    end
    load_req = 1'b0;
    ifa.m_ready = 1'b0;
    if (acc < 4) begin
      miscompares++;
      $display("FAIL store_timeout: got %0d beats expected 4", acc);
    end
    vectors++;
    if ({store_done, busy, ifa.m_valid, load_done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL store_finish: got done/busy/valid/ldone %b expected 1000",
               {store_done, busy, ifa.m_valid, load_done});
    end
`ifndef DCA_MATRIX_STREAM_ROTATE_EN
    for (int i = 0; i < 16; i++) mdl[i/4][i%4] = 8'h00;
`endif
    vectors++;
    if (rdata !== pack_mdl()) begin
      miscompares++;
      $display("FAIL store_matrix: got %h expected %h", rdata, pack_mdl());
    end
    @(negedge clk);
    vectors++;
    if ({store_done, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL store_idle: got done/busy %b expected 00", {store_done, busy});
    end
  endtask

  task automatic test_init_abort();
    @(negedge clk);
    load_req = 1'b1; col_mode = 1'b0;
    @(negedge clk);
    load_req = 1'b0;
    ifa.s_valid = 1'b1;
    repeat (2) begin
      ifa.s_data = $urandom;
      @(negedge clk);
    end
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    ifa.s_valid = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i/4][i%4] = InitV;
    vectors++;
    if ({busy, load_done} !== 2'b00) begin
      miscompares++;
      $display("FAIL init_abort_state: got busy/done %b expected 00", {busy, load_done});
    end
    vectors++;
    if (rdata !== pack_mdl()) begin
      miscompares++;
      $display("FAIL init_matrix: got %h expected %h", rdata, pack_mdl());
    end
    @(negedge clk);
    vectors++;
    if (load_done !== 1'b0) begin
      miscompares++;
      $display("FAIL init_no_done: got %b expected 0", load_done);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    store_req = 1'b1; col_mode = 1'b0;
    @(negedge clk);
    store_req = 1'b0;
    ifa.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) mdl[i/4][i%4] = 8'h00;
    vectors++;
    if ({busy, ifa.m_valid, store_done} !== 3'b000 || rdata !== pack_mdl()) begin
      miscompares++;
      $display("FAIL rst_mid: got state %b matrix %h expected 000 and %h",
               {busy, ifa.m_valid, store_done}, rdata, pack_mdl());
    end
    ifa.m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if ({busy, store_done} !== 2'b00) begin
        miscompares++;
        $display("FAIL rst_no_done: got busy/done %b expected 00", {busy, store_done});
      end
    end
  endtask

  task automatic test_two_rows();
    logic [63:0] beats [2];
    logic [63:0] expb [2];
    for (int j = 0; j < 2; j++) beats[j] = {$urandom, $urandom};
    for (int j = 0; j < 2; j++) for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++)
      mdlb[2*j+k][c] = beats[j][(k*4+c)*8 +: 8];
    @(negedge clk);
    b_load_req = 1'b1; b_col_mode = 1'b0;
    @(negedge clk);
    b_load_req = 1'b0;
    ifb.s_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      ifb.s_data = beats[j];
      @(negedge clk);
      vectors++;
      if ({b_load_done, b_busy} !== {1'(j == 1), 1'(j == 0)}) begin
        miscompares++;
        $display("FAIL r2_load_beat%0d: got done/busy %b expected %b", j,
                 {b_load_done, b_busy}, {1'(j == 1), 1'(j == 0)});
      end
    end
    ifb.s_valid = 1'b0;
    vectors++;
    if (b_rdata !== pack_mdlb()) begin
      miscompares++;
      $display("FAIL r2_load_matrix: got %h expected %h", b_rdata, pack_mdlb());
    end
    for (int j = 0; j < 2; j++) for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++)
      expb[j][(k*4+c)*8 +: 8] = mdlb[c][2*j+k];
    @(negedge clk);
    b_store_req = 1'b1; b_col_mode = 1'b1;
    @(negedge clk);
    b_store_req = 1'b0;
    ifb.m_ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      vectors++;
      if (ifb.m_data !== expb[j]) begin
        miscompares++;
        $display("FAIL r2_store_beat%0d: got %h expected %h", j, ifb.m_data, expb[j]);
      end
      @(negedge clk);
      vectors++;
      if (b_store_done !== 1'(j == 1)) begin
        miscompares++;
        $display("FAIL r2_store_done%0d: got %b expected %b", j, b_store_done, 1'(j == 1));
      end
    end
    ifb.m_ready = 1'b0;
`ifndef DCA_MATRIX_STREAM_ROTATE_EN
    for (int i = 0; i < 16; i++) mdlb[i/4][i%4] = 8'h00;
`endif
    vectors++;
    if (b_rdata !== pack_mdlb()) begin
      miscompares++;
      $display("FAIL r2_store_matrix: got %h expected %h", b_rdata, pack_mdlb());
    end
  endtask

  initial begin
    init = 1'b0; load_req = 1'b0; store_req = 1'b0; col_mode = 1'b0;
    wen = '0; wdata = '0;
    b_init = 1'b0; b_load_req = 1'b0; b_store_req = 1'b0; b_col_mode = 1'b0;
    b_wen = '0; b_wdata = '0;
    ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.m_ready = 1'b0;
    ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.m_ready = 1'b0;

    test_reset();
    test_idle_write();
    test_load(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    test_store(1'b0, 1'b1);
    test_load(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    test_store(1'b1, 1'b0);
    test_load(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    test_store(1'($urandom), 1'b0);
    for (int n = 0; n < 3; n++) begin
      test_idle_write();
      test_load(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      test_store(1'($urandom), 1'($urandom));
    end
    test_init_abort();
    test_rst_mid();
    test_two_rows();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dca_matrix_stream_register.md
DCA_MATRIX_STREAM_REGISTER -- requirements
Module: dca_matrix_stream_register

Interface
REQ-001 SHALL provide parameter MATRIX_SIZE_PARA, default 8: matrix is N x N with N = MATRIX_SIZE_PARA.
REQ-002 SHALL provide parameter BW_TENSOR_SCALAR, default 32: bits per element.
REQ-003 SHALL provide parameter ROWS_PER_BEAT (R), default 1: rows or columns moved per stream beat; N mod R = 0, else elaboration error.
REQ-004 SHALL provide parameters RESET_VALUE, default 0, and INIT_VALUE, default RESET_VALUE: per-element values applied by reset and by init.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 init  in  1  synchronous clear to INIT_VALUE, aborts any stream.
REQ-009 load_req / store_req  in  1 each  start a stream load or store from IDLE.
REQ-010 col_mode  in  1  sampled with a request: 0 selects rows, 1 selects columns.
REQ-011 s_valid in 1, s_ready out 1, s_data in R*N*BW_TENSOR_SCALAR  load stream.
REQ-012 m_valid out 1, m_ready in 1, m_data out R*N*BW_TENSOR_SCALAR  store stream.
REQ-013 busy  out 1; load_done / store_done  out 1 each, single-cycle pulses.
REQ-014 all_wenable_list2d in N*N, all_wdata_list2d in N*N*BW, all_rdata_list2d out N*N*BW  per-element parallel access.

Function
REQ-015 Element (r,c) SHALL occupy index r*N+c, bits [(r*N+c)*BW +: BW]; beat element (k,c) occupies index k*N+c, k in 0..R-1.
REQ-016 FSM states IDLE, LOAD, STORE; busy = (state != IDLE); s_ready = (state==LOAD); m_valid = (state==STORE).
REQ-017 IDLE: load_req -> LOAD, else store_req -> STORE; load wins when both are high; col_mode latched; beat counter cleared.
REQ-018 Requests SHALL be ignored outside IDLE.
REQ-019 LOAD row mode: each s_valid&s_ready beat shifts the matrix up by R rows and writes beat rows 0..R-1 into rows N-R..N-1.
REQ-020 LOAD column mode: each beat shifts left by R columns; beat row k, element c is written to element (c, N-R+k).
REQ-021 m_data SHALL be combinational: rows 0..R-1 in row mode; columns 0..R-1 in column mode, laid out as in REQ-020.
REQ-022 STORE: each m_valid&m_ready beat shifts up (row mode) or left (column mode) by R; vacated slots are filled per REQ-033.
REQ-023 Beat counter SHALL count accepted beats; on beat N/R the FSM returns to IDLE in the next cycle and pulses load_done or store_done in that cycle.
REQ-024 No beat SHALL be accepted in the cycle the FSM leaves LOAD or STORE.
REQ-025 all_wenable_list2d SHALL write its elements only in IDLE and SHALL be ignored in LOAD and STORE.
REQ-026 init SHALL have highest priority: all elements go to INIT_VALUE, FSM goes to IDLE, counter clears, no done pulse is issued.
REQ-027 all_rdata_list2d SHALL reflect register contents with no added latency.

Reset
REQ-028 On rst: all elements RESET_VALUE, FSM IDLE, counter 0.
REQ-029 Outputs during reset: busy=0, s_ready=0, m_valid=0, load_done=0, store_done=0.
REQ-030 On rst mid-stream, the partial stream SHALL be discarded with no done pulse.

Configuration
REQ-031 Macro DCA_MATRIX_STREAM_ROTATE_EN SHALL select the STORE fill behaviour.
REQ-032 When defined: the slots vacated in STORE are filled with the rows or columns just emitted, so the matrix is unchanged after a full store.
REQ-033 When undefined: vacated slots are filled with RESET_VALUE, leaving the matrix all RESET_VALUE after a full store.

Verification
REQ-034 N=4, R=1, BW=8: load rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with s_valid gapped -> element (r,c) = 4r+c; load_done one cycle after beat 4.
REQ-035 Same matrix, store with m_ready toggling 1,0,1,... -> m_data = 0x03020100, ..., 0x0F0E0D0C in order; then matrix unchanged with ROTATE_EN, all zero without.
REQ-036 col_mode=1 load of the same four beats -> element (c,j) = 4j+c, i.e. the transpose of REQ-034.
REQ-037 init asserted after 2 load beats -> all elements INIT_VALUE, busy=0 next cycle, no load_done.
REQ-038 load_req and store_req high together -> LOAD entered, store ignored; all_wenable=all ones during LOAD -> no effect.
REQ-039 R=2, N=4: two load beats fill the matrix; store emits two beats; done pulses after beat 2.
